imem_fetch_ctrl: RTL and testbench
==================================

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter: NOP_INST, 32'h0000_0013, data returned on misaligned fetch.
REQ-002 Parameter: CNT_W, 16, width of performance counters.
REQ-003 Reset rst, synchronous, active-high; clock clk.
REQ-004 clk  in  1  clock; all state on posedge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 inst_fetch_req  in  core::inst_fetch_req_t  fetch request: addr (rv32i::addr_t, 32), en (1).
REQ-007 inst_fetch_rsp  out  core::inst_fetch_rsp_t  fetch response: data (32), done (1).
REQ-008 flush  in  1  invalidate line buffer (fence.i / redirect).
REQ-009 fetch_err  out  1  misaligned fetch flag, valid while done=1.
REQ-010 mem_req  out  1  memory bus request.
REQ-011 mem_addr  out  32  memory bus word address.
REQ-012 mem_gnt  in  1  bus accepts request this cycle.
REQ-013 mem_rvalid  in  1  read data valid.
REQ-014 mem_rdata  in  32  read data.
REQ-015 miss_cnt, stale_cnt  out  CNT_W each  saturating counts of issued misses / discarded responses.

Function
REQ-016 One-entry line buffer SHALL hold buf_valid, buf_addr (32), buf_data (32).
REQ-017 Hit = req.en && buf_valid && req.addr == buf_addr && !flush; on hit rsp.done=1, rsp.data=buf_data, same cycle (combinational from registers).
REQ-018 Misaligned = req.en && req.addr[1:0] != 0; SHALL give rsp.done=1, rsp.data=NOP_INST, fetch_err=1 same cycle, no bus request, buffer unchanged.
REQ-019 Otherwise rsp.done=0, rsp.data=buf_data, fetch_err=0; req.en=0 SHALL force done=0 and no new bus request.
REQ-020 FSM states IDLE, ISSUE, WAIT.
REQ-021 IDLE: aligned non-hit with req.en -> ISSUE next cycle, latch iss_addr=req.addr, miss_cnt+1.
REQ-022 ISSUE: mem_req=1, mem_addr=iss_addr; mem_req/mem_addr SHALL stay stable until mem_gnt; on mem_gnt -> WAIT.
REQ-023 WAIT: mem_req=0; on mem_rvalid -> IDLE; if req.en && req.addr == iss_addr && no flush seen since issue, write buf_addr=iss_addr, buf_data=mem_rdata, buf_valid=1; else discard, stale_cnt+1.
REQ-024 mem_req SHALL be 0 in IDLE and WAIT; at most one outstanding transaction.
REQ-025 Address change during ISSUE SHALL NOT retarget the bus; completes and is discarded per REQ-023.
REQ-026 flush SHALL clear buf_valid next cycle and mark any ISSUE/WAIT transaction stale; flush and fill in the same cycle: flush wins (buf_valid=0).
REQ-027 Minimum miss latency: addr presented cycle N, mem_req cycle N+1, gnt N+1, rvalid N+2, done cycle N+3.
REQ-028 mem_rvalid in IDLE or ISSUE SHALL be ignored.
REQ-029 Counters SHALL saturate at all-ones, never wrap.

Reset
REQ-030 On rst: state=IDLE, buf_valid=0, buf_addr=0, buf_data=0, iss_addr=0, stale flag=0, miss_cnt=0, stale_cnt=0.
REQ-031 During/after rst: mem_req=0, rsp.done=0, fetch_err=0 unless misaligned with req.en per REQ-018.
REQ-032 rst mid-WAIT SHALL abandon the transaction; later mem_rvalid ignored per REQ-028.

Verification
REQ-033 Miss then hit: addr=0x100 en=1, gnt immediate, rvalid cycle N+2 rdata=0xDEADBEEF -> done=1 cycle N+3 data=0xDEADBEEF, miss_cnt=1; hold addr -> done stays 1, no mem_req.
REQ-034 Backpressure: gnt low 3 cycles -> mem_req=1, mem_addr=0x100 constant all 3 cycles; done 2 cycles after gnt.
REQ-035 Redirect: addr 0x200 to 0x300 during WAIT -> rvalid discarded, stale_cnt=1, buffer not 0x200, new request mem_addr=0x300.
REQ-036 Misaligned: addr=0x102 en=1 -> same-cycle done=1, data=0x00000013, fetch_err=1, mem_req never asserted.
REQ-037 Flush: buffer holds 0x100, pulse flush -> next cycle addr 0x100 misses, new request issued, miss_cnt increments.
REQ-038 Reset mid-WAIT: rst during WAIT, then rvalid -> ignored, buf_valid=0, counters 0, state IDLE.

Source files
------------

// File: rtl/imem_fetch_ctrl_if.sv
// Shared fetch types plus the port bundle between the core, the fetch controller and memory.
// The rv32i/core packages come first so the interface and the controller can use them.
// Modport master = fetch controller side; slave = core/memory environment side.

package rv32i;
  typedef logic [31:0] addr_t;
endpackage

package core;
  typedef struct packed {
    rv32i::addr_t addr;
    logic         en;
  } inst_fetch_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        done;
  } inst_fetch_rsp_t;
endpackage

interface imem_fetch_ctrl_if #(
  parameter int CNT_W = 16
);
  // Core-facing fetch port
  core::inst_fetch_req_t inst_fetch_req;
  core::inst_fetch_rsp_t inst_fetch_rsp;
  logic                  flush;
  logic                  fetch_err;

  // Memory bus: request/grant, then a single read-data beat
  logic                  mem_req;
  logic [31:0]           mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;

  // Performance counters
  logic [CNT_W-1:0]      miss_cnt;
  logic [CNT_W-1:0]      stale_cnt;

  modport master (
    input  inst_fetch_req, flush, mem_gnt, mem_rvalid, mem_rdata,
    output inst_fetch_rsp, fetch_err, mem_req, mem_addr, miss_cnt, stale_cnt
  );

  modport slave (
    output inst_fetch_req, flush, mem_gnt, mem_rvalid, mem_rdata,
    input  inst_fetch_rsp, fetch_err, mem_req, mem_addr, miss_cnt, stale_cnt
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller with a one-entry line buffer in front of a req/gnt/rvalid memory bus.
// Latency: hit/misaligned answered same cycle; miss returns done 3 cycles after addr at best.
// Backpressure: mem_req/mem_addr held stable until mem_gnt; at most one bus transaction in flight.

module imem_fetch_ctrl #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          CNT_W    = 16
) (
  input logic              clk,
  input logic              rst,
  imem_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Line buffer
  logic        buf_valid;
  logic [31:0] buf_addr;
  logic [31:0] buf_data;

  // In-flight transaction bookkeeping
  logic [31:0] iss_addr;
  logic        stale;

  logic [CNT_W-1:0] miss_cnt;
  logic [CNT_W-1:0] stale_cnt;

  // Decoded request
  logic        req_en;
  logic [31:0] req_addr;
  logic        misaligned;
  logic        hit;
  logic        miss;

  // FSM actions
  logic        start_miss;
  logic        fill;
  logic        discard;
  logic        mem_req;

  assign req_en   = bus.inst_fetch_req.en;
  assign req_addr = bus.inst_fetch_req.addr;

  // Classify the current request; hit is masked in reset so done stays low there.
  always_comb begin
    misaligned = req_en && (req_addr[1:0] != 2'b00);
    hit        = req_en && buf_valid && (req_addr == buf_addr) && !bus.flush && !rst;
    miss       = req_en && !misaligned && !hit;
  end

  // Core response: misaligned gives a NOP with the error flag, a hit returns buffered data.
  always_comb begin
    bus.inst_fetch_rsp.done = 1'b0;
    bus.inst_fetch_rsp.data = buf_data;
    bus.fetch_err           = 1'b0;
    if (misaligned) begin
      bus.inst_fetch_rsp.done = 1'b1;
      bus.inst_fetch_rsp.data = NOP_INST;
      bus.fetch_err           = 1'b1;
    end else if (hit) begin
      bus.inst_fetch_rsp.done = 1'b1;
    end
  end

  // Next-state and bus-side actions for the single outstanding transaction.
  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    start_miss = 1'b0;
    fill       = 1'b0;
    discard    = 1'b0;
    case (state)
      IDLE: begin
        if (miss) begin
          start_miss = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        mem_req = 1'b1;
        if (bus.mem_gnt) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_nxt = IDLE;
          // Keep the data only if the core still wants exactly this word and
          // nothing invalidated it in flight (a flush this very cycle counts too).
          if (req_en && (req_addr == iss_addr) && !stale && !bus.flush) begin
            fill = 1'b1;
          end else begin
            discard = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mem_req  = mem_req;
  assign bus.mem_addr = iss_addr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Line buffer update; flush overrides a fill landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else begin
      if (fill) begin
        buf_valid <= 1'b1;
        buf_addr  <= iss_addr;
        buf_data  <= bus.mem_rdata;
      end
      if (bus.flush) begin
        buf_valid <= 1'b0;
      end
    end
  end

  // Capture the miss address and track whether a flush hit the transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_addr <= '0;
      stale    <= 1'b0;
    end else if (start_miss) begin
      iss_addr <= req_addr;
      stale    <= 1'b0;
    end else if (bus.flush && (state != IDLE)) begin
      stale    <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt  <= '0;
      stale_cnt <= '0;
    end else begin
      if (start_miss && (miss_cnt != {CNT_W{1'b1}})) begin
        miss_cnt <= miss_cnt + 1'b1;
      end
      if (discard && (stale_cnt != {CNT_W{1'b1}})) begin
        stale_cnt <= stale_cnt + 1'b1;
      end
    end
  end

  assign bus.miss_cnt  = miss_cnt;
  assign bus.stale_cnt = stale_cnt;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: miss/hit timing, bus stall, redirect, misaligned, flush, reset.
// Inputs are driven 1ns after posedge and outputs sampled 1ns later.
// Counters are narrowed to 4 bits so saturation is reachable in a short run.

module tb_imem_fetch_ctrl;

  localparam int CW = 4;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  imem_fetch_ctrl_if #(.CNT_W(CW)) bus ();

  imem_fetch_ctrl #(
    .NOP_INST (32'h0000_0013),
    .CNT_W    (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] addr);
    bus.inst_fetch_req.en   = en;
    bus.inst_fetch_req.addr = addr;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.flush      = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    drive(1'b0, 32'h0);
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.flush      = 1'b0;
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    drive(1'b1, 32'h0000_0100);
    step();
    step();
    #1;
    n_chk++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
    n_chk++; if (bus.inst_fetch_rsp.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.inst_fetch_rsp.done); end
    n_chk++; if (bus.fetch_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.fetch_err); end
    n_chk++; if (bus.miss_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_miss_cnt: got %0d want 0", bus.miss_cnt); end
    n_chk++; if (bus.stale_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_stale_cnt: got %0d want 0", bus.stale_cnt); end
    drive(1'b1, 32'h0000_0102);
    #1;
    n_chk++; if (bus.inst_fetch_rsp.done !== 1'b1 || bus.fetch_err !== 1'b1) begin n_fail++; $display("FAIL rst_misaligned: got done=%b err=%b want 1 1", bus.inst_fetch_rsp.done, bus.fetch_err); end
    do_reset();
  endtask

  task automatic test_miss_then_hit();
    do_reset();
    drive(1'b1, 32'h0000_0100);
    bus.mem_gnt = 1'b1;
    #1;
    n_chk++; if (bus.inst_fetch_rsp.done !== 1'b0 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL mh_n: got done=%b req=%b want 0 0", bus.inst_fetch_rsp.done, bus.mem_req); end
    step();
    n_chk++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL mh_n1_req: got req=%b addr=%h want 1 00000100", bus.mem_req, bus.mem_addr); end
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    #1;
    n_chk++; if (bus.mem_req !== 1'b0 || bus.inst_fetch_rsp.done !== 1'b0) begin n_fail++; $display("FAIL mh_n2: got req=%b done=%b want 0 0", bus.mem_req, bus.inst_fetch_rsp.done); end
    step();
    bus.mem_rvalid = 1'b0;
    #1;
    n_chk++; if (bus.inst_fetch_rsp.done !== 1'b1 || bus.inst_fetch_rsp.data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mh_n3_done: got done=%b data=%h want 1 deadbeef", bus.inst_fetch_rsp.done, bus.inst_fetch_rsp.data); end
    n_chk++; if (bus.miss_cnt !== 4'd1) begin n_fail++; $display("FAIL mh_miss_cnt: got %0d want 1", bus.miss_cnt); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_chk++; if (bus.inst_fetch_rsp.done !== 1'b1 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL mh_hold%0d: got done=%b req=%b want 1 0", i, bus.inst_fetch_rsp.done, bus.mem_req); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, 32'h0000_0100);
    bus.mem_gnt = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hBAD0_BAD0;
      #1;
      n_chk++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL bp_stall%0d: got req=%b addr=%h want 1 00000100", i, bus.mem_req, bus.mem_addr); end
      step();
    end
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b0;
    #1;
    n_chk++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL bp_gnt: got req=%b addr=%h want 1 00000100", bus.mem_req, bus.mem_addr); end
    step();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    #1;
    n_chk++; if (bus.mem_req !== 1'b0 || bus.inst_fetch_rsp.done !== 1'b0) begin n_fail++; $display("FAIL bp_wait: got req=%b done=%b want 0 0", bus.mem_req, bus.inst_fetch_rsp.done); end
    step();
    bus.mem_rvalid = 1'b0;
    #1;
    n_chk++; if (bus.inst_fetch_rsp.done !== 1'b1 || bus.inst_fetch_rsp.data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL bp_done: got done=%b data=%h want 1 cafef00d", bus.inst_fetch_rsp.done, bus.inst_fetch_rsp.data); end
    n_chk++; if (bus.stale_cnt !== 4'd0) begin n_fail++; $display("FAIL bp_stale_cnt: got %0d want 0", bus.stale_cnt); end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(1'b1, 32'h0000_0200);
    bus.mem_gnt = 1'b1;
    step();
    #1;
    n_chk++; if (bus.mem_addr !== 32'h200) begin n_fail++; $display("FAIL rd_addr0: got %h want 00000200", bus.mem_addr); end
    step();
    drive(1'b1, 32'h0000_0300);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h2222_2222;
    step();
    bus.mem_rvalid = 1'b0;
    #1;
    n_chk++; if (bus.stale_cnt !== 4'd1) begin n_fail++; $display("FAIL rd_stale_cnt: got %0d want 1", bus.stale_cnt); end
    n_chk++; if (bus.inst_fetch_rsp.done !== 1'b0 || bus.inst_fetch_rsp.data !== 32'h0) begin n_fail++; $display("FAIL rd_nofill: got done=%b data=%h want 0 00000000", bus.inst_fetch_rsp.done, bus.inst_fetch_rsp.data); end
    step();
    n_chk++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300) begin n_fail++; $display("FAIL rd_newreq: got req=%b addr=%h want 1 00000300", bus.mem_req, bus.mem_addr); end
    n_chk++; if (bus.miss_cnt !== 4'd2) begin n_fail++; $display("FAIL rd_miss_cnt: got %0d want 2", bus.miss_cnt); end
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h3333_3333;
    step();
    bus.mem_rvalid = 1'b0;
    #1;
    n_chk++; if (bus.inst_fetch_rsp.done !== 1'b1 || bus.inst_fetch_rsp.data !== 32'h3333_3333) begin n_fail++; $display("FAIL rd_fill: got done=%b data=%h want 1 33333333", bus.inst_fetch_rsp.done, bus.inst_fetch_rsp.data); end
  endtask

  // Continues from test_redirect: buffer holds 0x300 -> 0x33333333.
  task automatic test_misaligned();
    drive(1'b1, 32'h0000_0102);
    #1;
    n_chk++; if (bus.inst_fetch_rsp.done !== 1'b1 || bus.inst_fetch_rsp.data !== 32'h0000_0013 || bus.fetch_err !== 1'b1) begin n_fail++; $display("FAIL mis_rsp: got done=%b data=%h err=%b want 1 00000013 1", bus.inst_fetch_rsp.done, bus.inst_fetch_rsp.data, bus.fetch_err); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_noreq%0d: got %b want 0", i, bus.mem_req); end
    end
    n_chk++; if (bus.miss_cnt !== 4'd2) begin n_fail++; $display("FAIL mis_miss_cnt: got %0d want 2", bus.miss_cnt); end
    drive(1'b1, 32'h0000_0300);
    #1;
    n_chk++; if (bus.inst_fetch_rsp.done !== 1'b1 || bus.inst_fetch_rsp.data !== 32'h3333_3333 || bus.fetch_err !== 1'b0) begin n_fail++; $display("FAIL mis_bufkept: got done=%b data=%h err=%b want 1 33333333 0", bus.inst_fetch_rsp.done, bus.inst_fetch_rsp.data, bus.fetch_err); end
  endtask

  // Continues from test_misaligned: buffer holds 0x300, miss_cnt=2, stale_cnt=1.
  task automatic test_flush();
    step();
    drive(1'b0, 32'h0000_0300);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(1'b1, 32'h0000_0300);
    bus.mem_gnt = 1'b1;
    #1;
    n_chk++; if (bus.inst_fetch_rsp.done !== 1'b0) begin n_fail++; $display("FAIL fl_miss: got done=%b want 0", bus.inst_fetch_rsp.done); end
    step();
    n_chk++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300) begin n_fail++; $display("FAIL fl_req: got req=%b addr=%h want 1 00000300", bus.mem_req, bus.mem_addr); end
    n_chk++; if (bus.miss_cnt !== 4'd3) begin n_fail++; $display("FAIL fl_miss_cnt: got %0d want 3", bus.miss_cnt); end
    step();
    bus.flush = 1'b1;
    step();
    bus.flush      = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h4444_4444;
    step();
    bus.mem_rvalid = 1'b0;
    #1;
    n_chk++; if (bus.stale_cnt !== 4'd2 || bus.inst_fetch_rsp.done !== 1'b0) begin n_fail++; $display("FAIL fl_wait_stale: got stale=%0d done=%b want 2 0", bus.stale_cnt, bus.inst_fetch_rsp.done); end
    step();
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_5555;
    bus.flush      = 1'b1;
    step();
    bus.mem_rvalid = 1'b0;
    bus.flush      = 1'b0;
    #1;
    n_chk++; if (bus.inst_fetch_rsp.done !== 1'b0 || bus.stale_cnt !== 4'd3) begin n_fail++; $display("FAIL fl_same_cycle: got done=%b stale=%0d want 0 3", bus.inst_fetch_rsp.done, bus.stale_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    drive(1'b1, 32'h0000_0500);
    bus.mem_gnt = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0000_0500);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h6666_6666;
    #1;
    n_chk++; if (bus.mem_req !== 1'b0 || bus.miss_cnt !== 4'd0 || bus.stale_cnt !== 4'd0) begin n_fail++; $display("FAIL rmw_after_rst: got req=%b miss=%0d stale=%0d want 0 0 0", bus.mem_req, bus.miss_cnt, bus.stale_cnt); end
    step();
    bus.mem_rvalid = 1'b0;
    drive(1'b1, 32'h0000_0500);
    #1;
    n_chk++; if (bus.inst_fetch_rsp.done !== 1'b0 || bus.stale_cnt !== 4'd0) begin n_fail++; $display("FAIL rmw_ignored: got done=%b stale=%0d want 0 0", bus.inst_fetch_rsp.done, bus.stale_cnt); end
    step();
    n_chk++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h500 || bus.miss_cnt !== 4'd1) begin n_fail++; $display("FAIL rmw_idle: got req=%b addr=%h miss=%0d want 1 00000500 1", bus.mem_req, bus.mem_addr, bus.miss_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.mem_gnt = 1'b1;
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 32'h0000_1000 + 32'(i * 4));
      step();
      step();
      drive(1'b0, 32'h0);
      bus.mem_rvalid = 1'b1;
      step();
      bus.mem_rvalid = 1'b0;
      #1;
      if (i == 9) begin
        n_chk++; if (bus.miss_cnt !== 4'd10 || bus.stale_cnt !== 4'd10) begin n_fail++; $display("FAIL sat_mid: got miss=%0d stale=%0d want 10 10", bus.miss_cnt, bus.stale_cnt); end
      end
    end
    n_chk++; if (bus.miss_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_miss: got %0d want 15", bus.miss_cnt); end
    n_chk++; if (bus.stale_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_stale: got %0d want 15", bus.stale_cnt); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    test_reset();
    test_miss_then_hit();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_flush();
    test_reset_mid_wait();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
